// File: rtl/k2_seq_pkg.sv
// k2_seq_pkg: shared state encoding and default widths for the K2 program sequencer.
package k2_seq_pkg;

  localparam int K2_SEQ_ADDR_W = 4;
  localparam int K2_SEQ_INST_W = 8;
  localparam int K2_SEQ_CYC_W  = 16;

  // Legacy-compatible state codes; the enum below is built on them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/k2_prog_store.sv
// k2_prog_store: instruction register array with one write port, an
// asynchronous read port and a single-cycle bulk clear. A write in the same
// cycle as a clear lands on top of the cleared contents.
module k2_prog_store
  import k2_seq_pkg::*;
#(
  parameter int ADDR_W = K2_SEQ_ADDR_W,
  parameter int INST_W = K2_SEQ_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem_reg [DEPTH];

  // Clear (reset or bulk) first, then let the write override its own entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end
    if (!rst && we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/k2_program_sequencer.sv
// k2_program_sequencer: loads the K2 instruction store from a host stream,
// holds the core in reset outside RUN, and ends a run on jump-to-self or stop.
// Optional watchdog: define K2_SEQ_WATCHDOG_EN to add WDOG_LIMIT and timeout.
module k2_program_sequencer
  import k2_seq_pkg::*;
#(
  parameter int ADDR_W = K2_SEQ_ADDR_W,
  parameter int INST_W = K2_SEQ_INST_W,
  parameter int CYC_W  = K2_SEQ_CYC_W
`ifdef K2_SEQ_WATCHDOG_EN
  , parameter int WDOG_LIMIT = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              stop,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [INST_W-1:0] cpu_inst,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  output logic [CYC_W-1:0]  cycle_count
`ifdef K2_SEQ_WATCHDOG_EN
  , output logic            timeout
`endif
);

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] prev_addr_reg, prev_addr_next;
  logic              run_seen_reg, run_seen_next;
  logic              loaded_reg, loaded_next;
  logic              done_reg, done_next;
  logic [CYC_W-1:0]  cycle_reg, cycle_next;
  logic              timeout_reg, timeout_next;
  logic              load_start;
  logic              store_we;

  k2_prog_store #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_start),
    .we    (store_we),
    .waddr (load_start ? '0 : wr_ptr_reg),
    .wdata (load_data),
    .raddr (cpu_addr),
    .rdata (cpu_inst)
  );

  // Next-state logic for the FSM, write pointer, address history and counter.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    prev_addr_next = prev_addr_reg;
    run_seen_next  = run_seen_reg;
    loaded_next    = loaded_reg;
    done_next      = done_reg;
    cycle_next     = cycle_reg;
    timeout_next   = timeout_reg;
    load_start     = 1'b0;
    store_we       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (load_valid) begin
          // First word is taken immediately at address 0 while the store clears.
          load_start   = 1'b1;
          store_we     = 1'b1;
          wr_ptr_next  = ADDR_W'(1);
          done_next    = 1'b0;
          timeout_next = 1'b0;
          loaded_next  = load_last;
          state_next   = load_last ? IDLE : LOAD;
        end else if (start && loaded_reg) begin
          state_next    = RUN;
          cycle_next    = '0;
          done_next     = 1'b0;
          timeout_next  = 1'b0;
          run_seen_next = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          store_we    = 1'b1;
          wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
          if (load_last || (&wr_ptr_reg)) begin
            loaded_next = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      RUN: begin
        cycle_next     = (&cycle_reg) ? cycle_reg : cycle_reg + CYC_W'(1);
        prev_addr_next = cpu_addr;
        run_seen_next  = 1'b1;
        if (stop) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (run_seen_reg && (cpu_addr == prev_addr_reg)) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
`ifdef K2_SEQ_WATCHDOG_EN
        else if (cycle_reg == CYC_W'(WDOG_LIMIT - 1)) begin
          state_next   = DONE;
          timeout_next = 1'b1;
          done_next    = 1'b0;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Register all sequencer state; reset discards any partial program or run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      prev_addr_reg <= '0;
      run_seen_reg  <= 1'b0;
      loaded_reg    <= 1'b0;
      done_reg      <= 1'b0;
      cycle_reg     <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      prev_addr_reg <= prev_addr_next;
      run_seen_reg  <= run_seen_next;
      loaded_reg    <= loaded_next;
      done_reg      <= done_next;
      cycle_reg     <= cycle_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign load_ready  = (state_reg == LOAD);
  assign cpu_rst_n   = (state_reg == RUN);
  assign busy        = (state_reg == LOAD) || (state_reg == RUN);
  assign done        = done_reg;
  assign loaded      = loaded_reg;
  assign cycle_count = cycle_reg;
`ifdef K2_SEQ_WATCHDOG_EN
  assign timeout     = timeout_reg;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_reg;
`endif

endmodule

// File: doc/k2_program_sequencer.md
# k2_program_sequencer

Program-memory controller and run sequencer for the K2 processor core. It owns a 16-entry instruction store, loads it from a host stream over a valid/ready handshake, and holds the core in reset while loading. It serves instructions combinationally to the core's program-address port, releases and re-asserts the core reset for each run, and detects program completion (jump-to-self). It replaces the fixed program ROM that sits beside `K2_processor` in the execution wrappers.

## Interface
- `ADDR_W`, default 4: program address width; the store depth is 2^ADDR_W.
- `INST_W`, default 8: instruction width.
- `CYC_W`, default 16: width of the run-cycle counter.

Ports (`rst` is synchronous and active-high):
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host instruction word is valid.
- `load_ready`  out  1  sequencer accepts a word this cycle.
- `load_data`  in  INST_W  instruction word to store.
- `load_last`  in  1  final word of the program.
- `start`  in  1  one-cycle pulse that begins a run.
- `stop`  in  1  one-cycle pulse that aborts a run.
- `cpu_rst_n`  out  1  active-low reset to `K2_processor`.
- `cpu_addr`  in  ADDR_W  the core's `ProgramAddress`.
- `cpu_inst`  out  INST_W  the core's `instruction_data`.
- `busy`  out  1  asserted in LOAD or RUN.
- `done`  out  1  the run finished by jump-to-self; held until the next load or start.
- `loaded`  out  1  the store holds at least one word.
- `cycle_count`  out  CYC_W  number of RUN cycles in the current or last run.

## Operation
States: IDLE, LOAD, RUN, DONE. Reset enters IDLE.

- **IDLE**
  - `load_valid` has priority over `start`: go to LOAD and accept that word in the same cycle at address 0.
  - On entry to LOAD, every store entry is cleared to 0 and `done` is cleared.
  - `start` with `loaded`=1 goes to RUN, clears `cycle_count` and clears `done`.
  - `start` with `loaded`=0 is ignored.
- **LOAD**
  - `load_ready`=1.
  - Each valid&ready beat writes `load_data` at the write pointer, then increments the pointer.
  - The beat with `load_last`=1, or the beat at address 2^ADDR_W-1, sets `loaded`=1 and returns to IDLE.
  - `start` and `stop` are ignored in LOAD.
- **RUN**
  - `cpu_rst_n`=1 and `cycle_count` increments every cycle, saturating at all-ones.
  - The previous `cpu_addr` is registered each cycle. From the second RUN cycle on, if `cpu_addr` equals the registered value, go to DONE and set `done`=1.
  - `stop` returns to IDLE with `done`=0.
  - `stop` has priority over completion detection when both occur in the same cycle.
- **DONE**
  - `cpu_rst_n`=0.
  - `start` reruns: same behaviour as `start` from IDLE.
  - `load_valid` goes to LOAD.
- **Outputs outside RUN:** `cpu_rst_n`=0 in every state except RUN.
- **Instruction read:** `cpu_inst` = store[`cpu_addr`] at all times, combinational.

## Timing
- **Reset values:** state IDLE, `load_ready`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `loaded`=0, `cycle_count`=0, write pointer 0, store all 0.
- **LOAD throughput:** one word per cycle. `load_ready` is combinational from state only, never from `load_valid`.
- **Run release:** `cpu_rst_n` rises in the cycle after the `start` sample. It falls in the cycle after `stop` or after completion is detected.
- **Completion latency:** `done` asserts one cycle after the second consecutive equal `cpu_addr` sample.
- **Read path:** `cpu_inst` has zero latency from `cpu_addr`.
- **Reset mid-operation:** `rst` during LOAD or RUN discards the partial program, clears `loaded`, and forces `cpu_rst_n`=0 in the same clock edge.

## Configuration
- **`K2_SEQ_WATCHDOG_EN` defined**
  - Adds parameter `WDOG_LIMIT` (default 1000) and output `timeout`.
  - In RUN, when `cycle_count` reaches `WDOG_LIMIT`, go to DONE with `timeout`=1 and `done`=0.
  - `timeout` clears on the next `start` or load.
- **`K2_SEQ_WATCHDOG_EN` not defined**
  - No `timeout` port; a run ends only by completion or `stop`.

## Structure
- **Package `k2_seq_pkg`:** the state enum `seq_state_t` (IDLE, LOAD, RUN, DONE) and the default width constants.
- **Sub-module `k2_prog_store`:** 2^ADDR_W × INST_W register array with one write port, an asynchronous read port and a bulk clear.
- **Top level:** the FSM, write pointer, address history register and counter.
- **Verification bench:** instantiates `K2_processor` with its `rst_n` driven by `cpu_rst_n`.

## Test plan
- **Load 3 words:** words 0x11, 0x22, 0x33 with `load_last` on the third → `loaded`=1, store[0..2] = 0x11/0x22/0x33, store[3..15] = 0, state IDLE.
- **Auto-terminate on full:** load 16 words without `load_last` → the 16th beat returns to IDLE; a 17th `load_valid` restarts LOAD at address 0 and clears the store.
- **Start and complete:** `start` after a load with `cpu_addr` held at 5 → `cpu_rst_n`=1 one cycle later, `done`=1, `cycle_count`=2, `cpu_rst_n`=0.
- **Stop beats completion:** `stop` asserted on the same cycle a repeated address is detected → IDLE, `done`=0.
- **Start ignored when empty:** `start` with `loaded`=0 → no state change and `cpu_rst_n` stays 0.
- **Watchdog (with `K2_SEQ_WATCHDOG_EN`, `WDOG_LIMIT`=8):** `cpu_addr` changes every cycle → `timeout`=1 after 8 RUN cycles, `done`=0.
